// File: rtl/cmip_pkg.sv
// Shared types and constants for the cmip bus synchronizer transmit end.
package cmip_pkg;

  // Transmit FSM states; encodings are fixed so they read the same in any dump.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  // An ack synchronizer shallower than this does not give metastability settling time.
  localparam int MIN_BUS_DELAY = 2;

  // Width of a counter that must be able to hold the value cyc; never narrower than 1.
  function automatic int cnt_width(input int cyc);
    int w;
    w = $clog2(cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cmip_bus_sync_tx_sync.sv
// Multi-flop level synchronizer cell. The input is asynchronous to i_clk and
// goes straight into the first flop with no logic in front of it.
module cmip_bus_sync_tx_sync #(
  parameter int DATA_WDTH = 1,
  parameter int BUS_DELAY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_WDTH-1:0] i_d,
  output logic [DATA_WDTH-1:0] o_q
);

  logic [BUS_DELAY-1:0][DATA_WDTH-1:0] stage_q;

  // Shift the asynchronous level through BUS_DELAY flops; stage 0 samples i_d directly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[BUS_DELAY-2:0], i_d};
    end
  end

  assign o_q = stage_q[BUS_DELAY-1];

endmodule

// File: rtl/cmip_bus_sync_tx.sv
// Transmit end of the two-phase req/ack toggle bus synchronizer. A word is
// captured on a valid/ready handshake, held on o_bus_data, and announced one
// cycle later by flipping o_req_toggle. The transfer completes once the
// returned ack level, synchronized locally, equals the req level.
module cmip_bus_sync_tx
  import cmip_pkg::*;
#(
  parameter int DATA_WDTH   = 32,
  parameter int BUS_DELAY   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 i_src_clk,
  input  logic                 i_src_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATA_WDTH-1:0] i_data,
  output logic [DATA_WDTH-1:0] o_bus_data,
  output logic                 o_req_toggle,
  input  logic                 i_ack_toggle,
  output logic                 o_done,
  output logic                 o_timeout
);

  localparam int             CNT_W      = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT_CYC);
  localparam bit             TIMEOUT_EN = (TIMEOUT_CYC != 0);

  // A shallow synchronizer would defeat the purpose of the ack path; stop elaboration.
  generate
    if (BUS_DELAY < MIN_BUS_DELAY) begin : g_bad_bus_delay
      $error("cmip_bus_sync_tx: BUS_DELAY must be at least %0d", MIN_BUS_DELAY);
    end
  endgenerate

  state_e               state_q;
  logic                 ready_q;
  logic                 done_q;
  logic                 req_q;
  logic                 timeout_q;
  logic [DATA_WDTH-1:0] bus_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 ack_sync;

  cmip_bus_sync_tx_sync #(
    .DATA_WDTH (1),
    .BUS_DELAY (BUS_DELAY)
  ) u_ack_sync (
    .i_clk (i_src_clk),
    .i_rst (i_src_rst),
    .i_d   (i_ack_toggle),
    .o_q   (ack_sync)
  );

  // Saturating next value of the WAIT_ACK cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Transfer FSM with registered handshake, data, req, done and timeout outputs.
  always_ff @(posedge i_src_clk) begin
    if (i_src_rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
      bus_q     <= '0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Ack level is deliberately not looked at here: a toggle from dst now is ignored.
          if (i_valid) begin
            bus_q   <= i_data;
            ready_q <= 1'b0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          // Data has been stable for one cycle before req moves.
          req_q   <= ~req_q;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_sync == req_q) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b1;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
            // Timeout only flags a slow dst; the transfer keeps waiting.
            if (TIMEOUT_EN && (cnt_d >= TO_VAL)) begin
              timeout_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready      = ready_q;
  assign o_done       = done_q;
  assign o_req_toggle = req_q;
  assign o_timeout    = timeout_q;
  assign o_bus_data   = bus_q;

endmodule
